// File: rtl/mac_tx_fcs_inserter.sv
// TX MAC stage: forwards frame bytes, zero-pads short frames, and appends the
// 4-byte Ethernet FCS (reflected CRC-32) behind a single output register.
module mac_tx_fcs_inserter #(
    parameter int PAD_EN      = 1,
    parameter int MIN_FRAME_B = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready
);

    typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

    localparam logic [5:0] MIN_CNT = 6'(MIN_FRAME_B);
    localparam bit         PAD_ON  = (PAD_EN != 0);

    state_t      state;
    logic [31:0] crc;
    logic [5:0]  byte_cnt;
    logic [5:0]  cnt_inc;
    logic [1:0]  fcs_idx;
    logic [31:0] crc_n;
    logic [7:0]  fcs_byte;
    logic        slot_free;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign slot_free = !m_valid || m_ready;
    // Held low during reset even though state already reads IDLE.
    assign s_ready   = rst_n && (state == IDLE || state == DATA) && slot_free;
    assign cnt_inc   = (byte_cnt < MIN_CNT) ? byte_cnt + 6'd1 : byte_cnt;
    assign crc_n     = ~crc;

    always_comb begin
        fcs_byte = '0;
        unique case (fcs_idx)
            2'd0: fcs_byte = crc_n[7:0];
            2'd1: fcs_byte = crc_n[15:8];
            2'd2: fcs_byte = crc_n[23:16];
            2'd3: fcs_byte = crc_n[31:24];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            crc      <= '1;
            byte_cnt <= '0;
            fcs_idx  <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
        end else if (slot_free) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            unique case (state)
                IDLE, DATA: begin
                    if (s_valid) begin
                        m_data   <= s_data;
                        m_valid  <= 1'b1;
                        crc      <= crc_byte(crc, s_data);
                        byte_cnt <= cnt_inc;
                        if (!s_last)
                            state <= DATA;
                        else if (PAD_ON && cnt_inc < MIN_CNT)
                            state <= PAD;
                        else
                            state <= FCS;
                    end
                end
                PAD: begin
                    m_data   <= '0;
                    m_valid  <= 1'b1;
                    crc      <= crc_byte(crc, 8'h00);
                    byte_cnt <= cnt_inc;
                    if (cnt_inc >= MIN_CNT)
                        state <= FCS;
                end
                FCS: begin
                    m_data  <= fcs_byte;
                    m_valid <= 1'b1;
                    m_last  <= (fcs_idx == 2'd3);
                    fcs_idx <= fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3) begin
                        state    <= IDLE;
                        crc      <= '1;
                        byte_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule
